iob_ila_capture: RTL
====================

Name: iob_ila_capture

Overview:
- Second-generation ILA capture engine. It samples a wide signal bus into an on-chip ring buffer on the system clock.
- Adds a programmable pre-trigger/post-trigger window, OR/AND trigger combination and per-trigger edge/level selection.
- Exposes the bus as DATA_W-wide readout channels.
- Sits behind the ILA register file; every configuration and status port maps one-to-one onto a software register.

Parameters:
- DATA_W, 32, readout word width; also the channel slice width.
- SIGNAL_W, 64, width of the sampled bus. CHANNELS = ceil(SIGNAL_W/DATA_W); CH_W = max(1, clog2(CHANNELS+1)).
- BUFFER_W, 10, log2 of buffer depth; DEPTH = 2^BUFFER_W samples.
- TRIGGER_W, 4, number of trigger inputs.

Ports:
- clk in 1: system clock; all logic on its rising edge.
- rst in 1: reset, asynchronous assert, active-low.
- signal in SIGNAL_W: bus sampled every cycle while capturing.
- trigger in TRIGGER_W: raw trigger inputs.
- trigger_mask in TRIGGER_W: 1 = trigger participates.
- trigger_negate in TRIGGER_W: 1 = invert the input before detection.
- trigger_type in TRIGGER_W: 0 = level, 1 = rising edge.
- trigger_mode in 1: 0 = OR of enabled triggers, 1 = AND of enabled triggers.
- pre_samples in BUFFER_W: samples kept before the trigger sample.
- post_samples in BUFFER_W: samples kept after the trigger sample.
- arm in 1: single-cycle pulse; starts a capture.
- abort in 1: single-cycle pulse; stops capture, returns to IDLE.
- state out 3: 0 IDLE, 1 PRE, 2 WAIT, 3 POST, 4 DONE.
- done out 1: high in DONE.
- samples out BUFFER_W+1: number of valid samples in the buffer.
- active_triggers out TRIGGER_W: per-trigger detect vector after mask, negate and type.
- rd_index in BUFFER_W: sample index; 0 = oldest valid sample.
- rd_select in CH_W: channel select.
- rd_data out DATA_W: selected sample slice, registered.

Behaviour:
- Reset: state=IDLE, done=0, samples=0, rd_data=0, active_triggers=0, write pointer=0, edge history=0.
- Trigger detect:
  - t = trigger ^ trigger_negate.
  - Edge bit = t & ~t_prev, where t_prev is registered every cycle regardless of state.
  - det = trigger_mask & (trigger_type ? edge : t).
  - hit = trigger_mode ? (det == trigger_mask) : |det.
  - trigger_mask = 0 → hit = 0 in both modes; the engine never triggers.
- Window clipping, latched at arm:
  - P = min(pre_samples, DEPTH-1).
  - Q = min(post_samples, DEPTH-1-P).
- IDLE: no writes. arm → PRE; write pointer = 0 and samples = 0 on that cycle.
- PRE:
  - Writes signal at wptr each cycle, wptr++, samples++.
  - Triggers are ignored.
  - When samples reaches P → WAIT. P = 0 → WAIT directly from arm.
- WAIT:
  - Writes each cycle; wptr wraps modulo DEPTH.
  - samples saturates at P+1 counting the current write. Older samples beyond P are overwritten logically.
  - hit → current sample is the trigger sample; record trig_ptr = wptr → POST, or → DONE if Q = 0.
- POST: writes Q further samples, then → DONE. Final samples = P+1+Q.
- DONE: no writes; done = 1. Only arm or abort leave DONE.
- Readout:
  - Oldest sample address = trig_ptr - P (mod DEPTH).
  - rd_data = slice rd_select of buffer[oldest + rd_index], one cycle after rd_index/rd_select.
  - Slices above SIGNAL_W are zero-padded.
  - rd_select ≥ CHANNELS returns 0, unless the optional feature below is compiled in.
  - Reads are legal in any state. Contents are defined only in DONE and for rd_index < samples.
- Simultaneous and mid-operation events:
  - arm and abort in the same cycle: abort wins → IDLE.
  - arm in PRE/WAIT/POST/DONE restarts the capture: pointers cleared, done=0.
  - hit on the arm cycle is ignored.
  - Reset mid-capture returns every output to its reset value; buffer contents are not cleared.
- active_triggers updates every cycle in all states.

Optional Feature:
- Macro ILA_TIMESTAMP_EN.
- Defined:
  - A DATA_W-wide cycle counter clears at arm and increments every cycle outside IDLE/DONE.
  - Its value is stored alongside each sample.
  - rd_select = CHANNELS returns that sample's timestamp; the trigger sample reads P.
  - The counter saturates at all-ones.
- Undefined: no counter and no extra storage; rd_select = CHANNELS returns 0.

Test Plan:
- Trigger and windowing: SIGNAL_W=64, DATA_W=32, pre=4, post=3, trigger[0] level, mask=1, mode OR; signal = incrementing counter; raise trigger when signal=20 → DONE, samples=8. rd_index 0..7, select 0 → 16..23; select 1 → 0.
- AND and edge modes: mask=0b0011, mode AND, type=0b0001; trigger[0] rises while trigger[1] low → no hit. Repeat with trigger[1] held high → hit on that cycle. Negate=0b0010 with trigger[1] low → also hits.
- Clipping and wrap: BUFFER_W=3, pre=7, post=7 → P=7, Q=0; trigger after 20 cycles → samples=8, rd_index 7 = trigger sample. Check wrapped addressing.
- Abort and re-arm: abort during WAIT → state=0, done=0. arm+abort in the same cycle → IDLE. arm during POST → state=PRE, samples=0.
- Asynchronous reset: drive rst=0 mid-POST for a partial cycle → state, done, samples and rd_data all 0 immediately, without a clock edge.
- ILA_TIMESTAMP_EN: pre=2, post=2, trigger on the 10th cycle after arm → timestamps for rd_index 0..4 read 0,1,2,3,4 (trigger sample = 2). With the macro undefined, rd_select = CHANNELS → 0.

Source files
------------

// File: rtl/iob_ila_capture.sv
// ILA capture engine: trigger detect, pre/post window into a ring buffer, sliced readout.
// Define ILA_TIMESTAMP_EN to store a per-sample cycle stamp, readable at rd_select == CHANNELS.
module iob_ila_capture #(
  parameter int DATA_W    = 32,
  parameter int SIGNAL_W  = 64,
  parameter int BUFFER_W  = 10,
  parameter int TRIGGER_W = 4,
  localparam int CHANNELS = (SIGNAL_W + DATA_W - 1) / DATA_W,
  localparam int CH_W     = (CHANNELS + 1 <= 2) ? 1 : $clog2(CHANNELS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SIGNAL_W-1:0]  signal,
  input  logic [TRIGGER_W-1:0] trigger,
  input  logic [TRIGGER_W-1:0] trigger_mask,
  input  logic [TRIGGER_W-1:0] trigger_negate,
  input  logic [TRIGGER_W-1:0] trigger_type,
  input  logic                 trigger_mode,
  input  logic [BUFFER_W-1:0]  pre_samples,
  input  logic [BUFFER_W-1:0]  post_samples,
  input  logic                 arm,
  input  logic                 abort,
  output logic [2:0]           state,
  output logic                 done,
  output logic [BUFFER_W:0]    samples,
  output logic [TRIGGER_W-1:0] active_triggers,
  input  logic [BUFFER_W-1:0]  rd_index,
  input  logic [CH_W-1:0]      rd_select,
  output logic [DATA_W-1:0]    rd_data
);
  // state | meaning
  // IDLE  | no capture, buffer untouched
  // PRE   | filling the P pre-trigger samples, triggers ignored
  // WAIT  | ring-writing, looking for a trigger hit
  // POST  | writing the Q post-trigger samples
  // DONE  | capture frozen, waiting for arm/abort
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_PRE = 3'd1, S_WAIT = 3'd2, S_POST = 3'd3, S_DONE = 3'd4
  } state_t;

  localparam int DEPTH = 1 << BUFFER_W;
  localparam int PAD_W = CHANNELS * DATA_W;

  state_t                state_q, state_d;
  logic [BUFFER_W-1:0]   wptr_q, wptr_d, trig_ptr_q, trig_ptr_d;
  logic [BUFFER_W-1:0]   p_q, p_d, q_q, q_d, post_cnt_q, post_cnt_d;
  logic [BUFFER_W:0]     samples_q, samples_d, p_inc;
  logic [TRIGGER_W-1:0]  t_prev_q, active_q;
  logic [TRIGGER_W-1:0]  t, edge_v, det;
  logic [BUFFER_W-1:0]   q_clip, rd_addr;
  logic [DATA_W-1:0]     rd_data_q, rd_data_d;
  logic [SIGNAL_W-1:0]   rd_sample;
  logic [PAD_W-1:0]      rd_word;
  logic                  hit, wr_en;
  logic [SIGNAL_W-1:0]   sample_mem [DEPTH];
`ifdef ILA_TIMESTAMP_EN
  logic [DATA_W-1:0]     ts_mem [DEPTH];
  logic [DATA_W-1:0]     ts_q, ts_d, trig_ts_q, trig_ts_d;
`endif

  always_comb begin
    t      = trigger ^ trigger_negate;
    edge_v = t & ~t_prev_q;
    det    = trigger_mask & ((trigger_type & edge_v) | (~trigger_type & t));
    hit    = (|trigger_mask) && (trigger_mode ? (det == trigger_mask) : (|det));
    // DEPTH-1-P is the bitwise inverse of P at BUFFER_W bits
    q_clip = (post_samples > ~pre_samples) ? ~pre_samples : post_samples;
    p_inc  = {1'b0, p_q} + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    samples_d  = samples_q;
    p_d        = p_q;
    q_d        = q_q;
    post_cnt_d = post_cnt_q;
    trig_ptr_d = trig_ptr_q;
    wr_en      = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else if (arm) begin
      p_d        = pre_samples;
      q_d        = q_clip;
      wptr_d     = '0;
      samples_d  = '0;
      trig_ptr_d = '0;
      state_d    = (pre_samples == '0) ? S_WAIT : S_PRE;
    end else begin
      case (state_q)
        S_PRE: begin
          wr_en     = 1'b1;
          wptr_d    = wptr_q + 1'b1;
          samples_d = samples_q + 1'b1;
          if (samples_q + 1'b1 == {1'b0, p_q}) state_d = S_WAIT;
        end
        S_WAIT: begin
          wr_en     = 1'b1;
          wptr_d    = wptr_q + 1'b1;
          samples_d = (samples_q == p_inc) ? p_inc : samples_q + 1'b1;
          if (hit) begin
            trig_ptr_d = wptr_q;
            post_cnt_d = q_q;
            state_d    = (q_q == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          wr_en      = 1'b1;
          wptr_d     = wptr_q + 1'b1;
          samples_d  = samples_q + 1'b1;
          post_cnt_d = post_cnt_q - 1'b1;
          if (post_cnt_q == {{(BUFFER_W-1){1'b0}}, 1'b1}) state_d = S_DONE;
        end
        default: ;
      endcase
    end
  end

`ifdef ILA_TIMESTAMP_EN
  always_comb begin
    ts_d      = ts_q;
    trig_ts_d = trig_ts_q;
    if (!abort && arm) begin
      ts_d = '0;
    end else if (!abort) begin
      if ((state_q == S_PRE || state_q == S_WAIT || state_q == S_POST) && ts_q != '1)
        ts_d = ts_q + 1'b1;
      if (state_q == S_WAIT && hit) trig_ts_d = ts_q;
    end
  end
`endif

  always_comb begin
    rd_addr   = trig_ptr_q - p_q + rd_index;
    rd_sample = sample_mem[rd_addr];
    rd_word   = PAD_W'(rd_sample);
    rd_data_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (rd_select == CH_W'(c)) rd_data_d = rd_word[c*DATA_W +: DATA_W];
    end
`ifdef ILA_TIMESTAMP_EN
    // stamps are reported relative to the window so the trigger sample reads P
    if (rd_select == CH_W'(CHANNELS)) rd_data_d = ts_mem[rd_addr] - trig_ts_q + DATA_W'(p_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      sample_mem[wptr_q] <= signal;
`ifdef ILA_TIMESTAMP_EN
      ts_mem[wptr_q] <= ts_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      trig_ptr_q <= '0;
      p_q        <= '0;
      q_q        <= '0;
      post_cnt_q <= '0;
      samples_q  <= '0;
      t_prev_q   <= '0;
      active_q   <= '0;
      rd_data_q  <= '0;
`ifdef ILA_TIMESTAMP_EN
      ts_q       <= '0;
      trig_ts_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      trig_ptr_q <= trig_ptr_d;
      p_q        <= p_d;
      q_q        <= q_d;
      post_cnt_q <= post_cnt_d;
      samples_q  <= samples_d;
      t_prev_q   <= t;
      active_q   <= det;
      rd_data_q  <= rd_data_d;
`ifdef ILA_TIMESTAMP_EN
      ts_q       <= ts_d;
      trig_ts_q  <= trig_ts_d;
`endif
    end
  end

  assign state           = state_q;
  assign done            = (state_q == S_DONE);
  assign samples         = samples_q;
  assign active_triggers = active_q;
  assign rd_data         = rd_data_q;

endmodule
